// File: rtl/dmux_pkg.sv
// Shared constants for the 4-way registered demultiplexer.
// Lane select codes, lane count and the stats counter width.
package dmux_pkg;

    localparam logic [1:0] SEL_A = 2'b00;
    localparam logic [1:0] SEL_B = 2'b01;
    localparam logic [1:0] SEL_C = 2'b10;
    localparam logic [1:0] SEL_D = 2'b11;

    localparam int NUM_LANES = 4;
    localparam int STAT_W    = 8;

endpackage

// File: rtl/dmux_lane_buf.sv
// Single-entry holding register with load and valid/ready drain.
// A load always wins over a drain on the same edge.
module dmux_lane_buf #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             ready,
    output logic [WIDTH-1:0] dout,
    output logic             valid
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout  <= '0;
            valid <= 1'b0;
        end else if (load) begin
            dout  <= din;
            valid <= 1'b1;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/dmux4way16_buf.sv
// Registered 4-way demux into independent single-entry lane buffers.
// Optional per-lane acceptance counters with DMUX4WAY16_STATS_EN.
module dmux4way16_buf
    import dmux_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic [1:0]       sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic             a_valid,
    output logic             b_valid,
    output logic             c_valid,
    output logic             d_valid,
    input  logic             a_ready,
    input  logic             b_ready,
    input  logic             c_ready,
    input  logic             d_ready
`ifdef DMUX4WAY16_STATS_EN
    ,
    output logic [STAT_W-1:0] a_count,
    output logic [STAT_W-1:0] b_count,
    output logic [STAT_W-1:0] c_count,
    output logic [STAT_W-1:0] d_count
`endif
);

    logic [NUM_LANES-1:0] vld;
    logic [NUM_LANES-1:0] rdy;
    logic [NUM_LANES-1:0] hit;
    logic [NUM_LANES-1:0] load;
    logic [WIDTH-1:0]     dat [NUM_LANES];

    assign rdy = {d_ready, c_ready, b_ready, a_ready};

    always_comb begin
        hit = '0;
        unique case (sel)
            SEL_A: hit = 4'b0001;
            SEL_B: hit = 4'b0010;
            SEL_C: hit = 4'b0100;
            SEL_D: hit = 4'b1000;
        endcase
    end

    // Only the addressed lane gates the producer.
    assign in_ready = |(hit & (~vld | rdy));
    assign load     = (in_valid && in_ready) ? hit : '0;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        dmux_lane_buf #(.WIDTH(WIDTH)) u_buf (
            .clk   (clk),
            .reset (reset),
            .load  (load[i]),
            .din   (in),
            .ready (rdy[i]),
            .dout  (dat[i]),
            .valid (vld[i])
        );
    end

    assign a       = dat[0];
    assign b       = dat[1];
    assign c       = dat[2];
    assign d       = dat[3];
    assign a_valid = vld[0];
    assign b_valid = vld[1];
    assign c_valid = vld[2];
    assign d_valid = vld[3];

`ifdef DMUX4WAY16_STATS_EN
    logic [STAT_W-1:0] cnt [NUM_LANES];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_LANES; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_LANES; i++)
                if (load[i]) cnt[i] <= cnt[i] + STAT_W'(1);
        end
    end

    assign a_count = cnt[0];
    assign b_count = cnt[1];
    assign c_count = cnt[2];
    assign d_count = cnt[3];
`endif

endmodule

// File: tb/tb_dmux4way16_buf.sv
// Self-checking bench for dmux4way16_buf (vectors, sequences, random).
// Build with DMUX4WAY16_STATS_EN to include the counter checks.
module tb_dmux4way16_buf;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] din;
    logic [1:0]  sel;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  rdy;
    logic [15:0] a, b, c, d;
    logic        a_valid, b_valid, c_valid, d_valid;
`ifdef DMUX4WAY16_STATS_EN
    logic [7:0]  a_count, b_count, c_count, d_count;
`endif

    int checks   = 0;
    int failures = 0;

    logic [15:0] q [4][$];
`ifdef DMUX4WAY16_STATS_EN
    int cnt_m [4];
`endif

    always #5 clk = ~clk;

    dmux4way16_buf #(.WIDTH(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .in       (din),
        .sel      (sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .c        (c),
        .d        (d),
        .a_valid  (a_valid),
        .b_valid  (b_valid),
        .c_valid  (c_valid),
        .d_valid  (d_valid),
        .a_ready  (rdy[0]),
        .b_ready  (rdy[1]),
        .c_ready  (rdy[2]),
        .d_ready  (rdy[3])
`ifdef DMUX4WAY16_STATS_EN
        ,
        .a_count  (a_count),
        .b_count  (b_count),
        .c_count  (c_count),
        .d_count  (d_count)
`endif
    );

    function automatic logic [15:0] lane(input int i);
        case (i)
            0: return a;
            1: return b;
            2: return c;
            default: return d;
        endcase
    endfunction

    function automatic logic lvalid(input int i);
        case (i)
            0: return a_valid;
            1: return b_valid;
            2: return c_valid;
            default: return d_valid;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 4; i++) begin
            q[i].delete();
`ifdef DMUX4WAY16_STATS_EN
            cnt_m[i] = 0;
`endif
        end
    endtask

    // Model: each lane is a FIFO of accepted-but-undelivered words.
    task automatic cyc();
        logic       er;
        logic [1:0] s;
        #1;
        s  = sel;
        er = (q[s].size() == 0) || rdy[s];
        chk("in_ready", {31'b0, in_ready}, {31'b0, er});
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("valid%0d", i), {31'b0, lvalid(i)},
                {31'b0, q[i].size() != 0});
            if (q[i].size() != 0)
                chk($sformatf("data%0d", i), {16'b0, lane(i)},
                    {16'b0, q[i][0]});
        end
        for (int i = 0; i < 4; i++)
            if (q[i].size() != 0 && rdy[i]) void'(q[i].pop_front());
        if (in_valid && er) begin
            q[s].push_back(din);
`ifdef DMUX4WAY16_STATS_EN
            cnt_m[s] = (cnt_m[s] + 1) % 256;
`endif
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input string nm);
        chk({nm, "_valids"}, {28'b0, d_valid, c_valid, b_valid, a_valid}, 0);
        chk({nm, "_lanes"}, {a | b | c | d}, 0);
        chk({nm, "_in_ready"}, {31'b0, in_ready}, 1);
    endtask

    typedef struct {
        logic [1:0]  sel;
        logic [15:0] din;
        logic [3:0]  ev;
    } vec_t;

    vec_t tbl [6];

    initial begin
        tbl[0] = '{2'b00, 16'h1111, 4'b0001};
        tbl[1] = '{2'b01, 16'h2222, 4'b0010};
        tbl[2] = '{2'b10, 16'h4444, 4'b0100};
        tbl[3] = '{2'b11, 16'h8888, 4'b1000};
        tbl[4] = '{2'b10, 16'h5A5A, 4'b0100};
        tbl[5] = '{2'b00, 16'hFFFF, 4'b0001};

        reset = 1'b1;
        din = '0; sel = '0; in_valid = 1'b0; rdy = 4'hF;
        clear_model();
        #3;
        chk_reset_state("por");
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        // steering, one word per cycle, all consumers ready
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1; sel = tbl[k].sel; din = tbl[k].din;
            cyc();
            chk($sformatf("steer%0d_v", k),
                {28'b0, d_valid, c_valid, b_valid, a_valid},
                {28'b0, tbl[k].ev});
            chk($sformatf("steer%0d_d", k), {16'b0, lane(int'(tbl[k].sel))},
                {16'b0, tbl[k].din});
        end
        in_valid = 1'b0;
        cyc();

        // stall isolation on lane b
        rdy = 4'b1101;
        in_valid = 1'b1; sel = 2'b01; din = 16'h2222;
        cyc();
        din = 16'h2223;
        #1;
        chk("stall_b_in_ready", {31'b0, in_ready}, 0);
        cyc();
        for (int k = 0; k < 6; k++) begin
            sel = (k % 2 == 1) ? 2'b01 : 2'(k / 2 == 0 ? 0 : k / 2 + 1);
            din = (k % 2 == 1) ? 16'h2223 : 16'h3000 + 16'(k);
            cyc();
            chk("stall_b_hold", {15'b0, b_valid, b}, {15'b0, 1'b1, 16'h2222});
        end
        in_valid = 1'b0; rdy = 4'hF;
        cyc(); cyc();

        // back-to-back stream into lane c
        in_valid = 1'b1; sel = 2'b10;
        for (int k = 1; k <= 16; k++) begin
            din = 16'(k);
            cyc();
            chk("b2b_c", {15'b0, c_valid, c}, {15'b0, 1'b1, 16'(k)});
        end
        in_valid = 1'b0;
        cyc(); cyc();

        // reset while lanes a and d are stalled
        rdy = 4'b0000;
        in_valid = 1'b1; sel = 2'b00; din = 16'hAAAA;
        cyc();
        sel = 2'b11; din = 16'hDDDD;
        cyc();
        in_valid = 1'b0;
        chk("pre_rst_ad", {30'b0, d_valid, a_valid}, 3);
        reset = 1'b1;
        #1;
        chk_reset_state("mid");
        clear_model();
        @(posedge clk); #1;
        reset = 1'b0; rdy = 4'hF;
        for (int k = 0; k < 3; k++) cyc();

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            in_valid = 1'($urandom_range(0, 1));
            sel      = 2'($urandom);
            din      = 16'($urandom);
            rdy      = 4'($urandom);
            cyc();
        end
        in_valid = 1'b0; rdy = 4'hF;
        cyc(); cyc();

`ifdef DMUX4WAY16_STATS_EN
        reset = 1'b1;
        #1;
        clear_model();
        chk("stat_rst", {a_count, b_count, c_count, d_count}, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        in_valid = 1'b1; sel = 2'b11;
        for (int k = 0; k < 257; k++) begin
            din = 16'($urandom);
            cyc();
        end
        in_valid = 1'b0;
        cyc();
        chk("stat_d", {24'b0, d_count}, 1);
        chk("stat_abc", {8'b0, a_count, b_count, c_count}, 0);
        chk("stat_model", {24'b0, d_count}, 32'(cnt_m[3]));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
